// File: rtl/modulo_gerenciador_rolhas_param.sv
// Cork-stock manager: main store feeding the sealer, operator-loaded reservoir,
// batch refill FSM (IDLE/XFER) and sealed-bottle dozen counting.
// Ports:
//   clk, Nclr        clock and synchronous active-low clear
//   enable           run; 0 freezes all registers and silences pulses
//   res_add          +1 cork into the reservoir
//   op_req           manual refill request
//   consume          a cork is used this cycle
//   main_level       main-store count
//   res_level        reservoir count
//   ro, min_flag     combinational empty / low-level flags on main_level
//   xfer_busy        FSM in XFER
//   xfer_done        one-cycle pulse after the final move of a refill
//   res_ovf          sticky reservoir-full rejection flag
//   dozen_pulse      one-cycle pulse per completed dozen
//   dozens           dozen count, 0..DZ_MAX-1
//   dz_wrap          one-cycle pulse when dozens wraps
module modulo_gerenciador_rolhas_param #(
  parameter int unsigned W         = 7,
  parameter int unsigned CAP_MAIN  = 99,
  parameter int unsigned CAP_RES   = 99,
  parameter int unsigned MIN_LEVEL = 5,
  parameter int unsigned BATCH     = 20,
  parameter int unsigned DOZEN     = 12,
  parameter int unsigned DZ_MAX    = 10,
  parameter int unsigned DZ_W      = 4
) (
  input  logic            clk,
  input  logic            Nclr,
  input  logic            enable,
  input  logic            res_add,
  input  logic            op_req,
  input  logic            consume,
  output logic [W-1:0]    main_level,
  output logic [W-1:0]    res_level,
  output logic            ro,
  output logic            min_flag,
  output logic            xfer_busy,
  output logic            xfer_done,
  output logic            res_ovf,
  output logic            dozen_pulse,
  output logic [DZ_W-1:0] dozens,
  output logic            dz_wrap
);

  localparam int unsigned BW  = (DOZEN > 1) ? $clog2(DOZEN) : 1;
  localparam int unsigned MVW = $clog2(BATCH + 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    main_q, main_d;
  logic [W-1:0]    res_q, res_d;
  logic [MVW-1:0]  moved_q, moved_d;
  logic [BW-1:0]   bottle_q, bottle_d;
  logic [DZ_W-1:0] dozens_q, dozens_d;
  logic            res_ovf_q, res_ovf_d;
  logic            done_q, done_d;
  logic            dp_q, dp_d;
  logic            dzw_q, dzw_d;

  logic can_move, move, cons_ok, add_ok;

  // Next-state: net level update, refill FSM, dozen counting
  always_comb begin
    state_d   = state_q;
    main_d    = main_q;
    res_d     = res_q;
    moved_d   = moved_q;
    bottle_d  = bottle_q;
    dozens_d  = dozens_q;
    res_ovf_d = res_ovf_q;
    done_d    = 1'b0;
    dp_d      = 1'b0;
    dzw_d     = 1'b0;
    can_move  = (res_q != '0) && (main_q < W'(CAP_MAIN));
    move      = 1'b0;
    cons_ok   = 1'b0;
    add_ok    = 1'b0;

    if (enable) begin
      move    = (state_q == XFER) && can_move;
      cons_ok = consume && (main_q != '0);
      // A same-cycle move frees one slot, so the add fits even at the cap
      add_ok  = res_add && ((res_q < W'(CAP_RES)) || move);
      if (res_add && !add_ok) res_ovf_d = 1'b1;

      main_d = main_q + W'(move) - W'(cons_ok);
      res_d  = res_q + W'(add_ok) - W'(move);

      case (state_q)
        IDLE: begin
          if ((min_flag || op_req) && can_move) begin
            state_d = XFER;
            moved_d = '0;
          end
        end
        XFER: begin
          if (!move) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            moved_d = moved_q + MVW'(1);
            if ((moved_d == MVW'(BATCH)) || (res_d == '0) || (main_d == W'(CAP_MAIN))) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase

      if (cons_ok) begin
        if (bottle_q == BW'(DOZEN - 1)) begin
          bottle_d = '0;
          dp_d     = 1'b1;
          if (dozens_q == DZ_W'(DZ_MAX - 1)) begin
            dozens_d = '0;
            dzw_d    = 1'b1;
          end else begin
            dozens_d = dozens_q + DZ_W'(1);
          end
        end else begin
          bottle_d = bottle_q + BW'(1);
        end
      end
    end
  end

  // State register with synchronous clear
  always_ff @(posedge clk) begin
    if (!Nclr) begin
      state_q   <= IDLE;
      main_q    <= '0;
      res_q     <= '0;
      moved_q   <= '0;
      bottle_q  <= '0;
      dozens_q  <= '0;
      res_ovf_q <= 1'b0;
      done_q    <= 1'b0;
      dp_q      <= 1'b0;
      dzw_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      res_q     <= res_d;
      moved_q   <= moved_d;
      bottle_q  <= bottle_d;
      dozens_q  <= dozens_d;
      res_ovf_q <= res_ovf_d;
      done_q    <= done_d;
      dp_q      <= dp_d;
      dzw_q     <= dzw_d;
    end
  end

  assign main_level  = main_q;
  assign res_level   = res_q;
  assign ro          = (main_q == '0);
  assign min_flag    = (main_q <= W'(MIN_LEVEL));
  assign xfer_busy   = (state_q == XFER);
  assign xfer_done   = done_q;
  assign res_ovf     = res_ovf_q;
  assign dozen_pulse = dp_q;
  assign dozens      = dozens_q;
  assign dz_wrap     = dzw_q;

endmodule

// File: tb/tb_modulo_gerenciador_rolhas_param.sv
module tb_modulo_gerenciador_rolhas_param;

  logic       clk, Nclr, enable, res_add, op_req, consume;
  logic [6:0] main_level, res_level;
  logic       ro, min_flag, xfer_busy, xfer_done, res_ovf, dozen_pulse, dz_wrap;
  logic [3:0] dozens;

  int n_pass, n_total;
  int done_cnt, busy_cnt, dp_cnt, dzw_cnt;

  modulo_gerenciador_rolhas_param dut (
    .clk(clk), .Nclr(Nclr), .enable(enable), .res_add(res_add),
    .op_req(op_req), .consume(consume), .main_level(main_level),
    .res_level(res_level), .ro(ro), .min_flag(min_flag),
    .xfer_busy(xfer_busy), .xfer_done(xfer_done), .res_ovf(res_ovf),
    .dozen_pulse(dozen_pulse), .dozens(dozens), .dz_wrap(dz_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic nclr, en, add, req, cons;
    int   main, res;
    logic busy, done, ovf, ro, mn;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic set_in(input logic n, input logic e, input logic a, input logic r, input logic c);
    Nclr = n; enable = e; res_add = a; op_req = r; consume = c;
  endtask

  task automatic step();
    @(posedge clk); #1;
    if (xfer_done)   done_cnt++;
    if (xfer_busy)   busy_cnt++;
    if (dozen_pulse) dp_cnt++;
    if (dz_wrap)     dzw_cnt++;
  endtask

  task automatic idle(input int n);
    set_in(1, 1, 0, 0, 0);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    set_in(0, 1, 0, 0, 0);
    step();
    set_in(1, 1, 0, 0, 0);
    done_cnt = 0; busy_cnt = 0; dp_cnt = 0; dzw_cnt = 0;
  endtask

  task automatic adds(input int n);
    set_in(1, 1, 1, 0, 0);
    for (int i = 0; i < n; i++) step();
    res_add = 0;
  endtask

  task automatic wait_idle(input int n);
    for (int i = 0; i < n && xfer_busy; i++) step();
    chk("wait_idle_bound", int'(xfer_busy), 0);
  endtask

  task automatic op_refill();
    set_in(1, 1, 0, 1, 0);
    step();
    op_req = 0;
    wait_idle(40);
    idle(2);
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    done_cnt = 0; busy_cnt = 0; dp_cnt = 0; dzw_cnt = 0;
    set_in(0, 1, 1, 1, 1);

    //            nclr en add req cons main res busy done ovf ro mn
    tbl[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    for (int i = 0; i < 10; i++) begin
      set_in(tbl[i].nclr, tbl[i].en, tbl[i].add, tbl[i].req, tbl[i].cons);
      step();
      chk($sformatf("vec%0d_main", i), int'(main_level), tbl[i].main);
      chk($sformatf("vec%0d_res", i),  int'(res_level),  tbl[i].res);
      chk($sformatf("vec%0d_busy", i), int'(xfer_busy),  int'(tbl[i].busy));
      chk($sformatf("vec%0d_done", i), int'(xfer_done),  int'(tbl[i].done));
      chk($sformatf("vec%0d_ovf", i),  int'(res_ovf),    int'(tbl[i].ovf));
      chk($sformatf("vec%0d_ro", i),   int'(ro),         int'(tbl[i].ro));
      chk($sformatf("vec%0d_min", i),  int'(min_flag),   int'(tbl[i].mn));
    end

    // Automatic refill while 30 adds stream in
    do_reset();
    set_in(1, 1, 1, 0, 0);
    for (int i = 1; i <= 30; i++) begin
      step();
      if (i == 10) begin
        chk("auto_mid_main", int'(main_level), 8);
        chk("auto_mid_res_add_during_move", int'(res_level), 2);
      end
    end
    idle(3);
    chk("auto_main", int'(main_level), 20);
    chk("auto_res", int'(res_level), 10);
    chk("auto_busy", int'(xfer_busy), 0);
    chk("auto_done_cnt", done_cnt, 1);

    // Refill limited by reservoir: main=3, 7 corks in reservoir
    do_reset();
    for (int k = 0; k < 3; k++) begin adds(1); idle(4); end
    chk("lim_pre_main", int'(main_level), 3);
    chk("lim_pre_res", int'(res_level), 0);
    done_cnt = 0; busy_cnt = 0;
    adds(7);
    idle(6);
    chk("lim_main", int'(main_level), 10);
    chk("lim_res", int'(res_level), 0);
    chk("lim_busy_cycles", busy_cnt, 7);
    chk("lim_done_cnt", done_cnt, 1);

    // Consume held through a manual refill leaves main unchanged
    adds(5);
    idle(2);
    chk("sim_pre_res", int'(res_level), 5);
    chk("sim_pre_busy", int'(xfer_busy), 0);
    done_cnt = 0;
    set_in(1, 1, 0, 1, 0);
    step();
    op_req = 0;
    chk("sim_entry_busy", int'(xfer_busy), 1);
    for (int i = 0; i < 10 && xfer_busy; i++) begin
      consume = 1;
      step();
      chk("sim_main_const", int'(main_level), 10);
    end
    consume = 0;
    chk("sim_exit_busy", int'(xfer_busy), 0);
    chk("sim_res", int'(res_level), 0);
    chk("sim_done_cnt", done_cnt, 1);

    // Manual refills, op_req during XFER ignored, then overflow
    do_reset();
    adds(99);
    idle(3);
    chk("man_pre_main", int'(main_level), 20);
    chk("man_pre_res", int'(res_level), 79);
    set_in(1, 1, 0, 1, 0);
    step();
    op_req = 0;
    idle(5);
    op_req = 1;
    step();
    op_req = 0;
    wait_idle(40);
    idle(3);
    chk("man_dup_req_main", int'(main_level), 40);
    chk("man_dup_req_res", int'(res_level), 59);
    chk("man_dup_req_busy", int'(xfer_busy), 0);
    op_refill(); op_refill(); op_refill();
    chk("man_cap_main", int'(main_level), 99);
    chk("man_cap_res", int'(res_level), 0);
    set_in(1, 1, 0, 0, 1);
    for (int i = 0; i < 9; i++) step();
    consume = 0;
    adds(50);
    idle(2);
    chk("man90_main", int'(main_level), 90);
    chk("man90_res", int'(res_level), 50);
    chk("man90_idle", int'(xfer_busy), 0);
    done_cnt = 0; busy_cnt = 0;
    op_refill();
    chk("man_main", int'(main_level), 99);
    chk("man_res", int'(res_level), 41);
    chk("man_moves", busy_cnt, 9);
    chk("man_done_cnt", done_cnt, 1);
    adds(58);
    idle(1);
    chk("ovf_full_res", int'(res_level), 99);
    chk("ovf_before", int'(res_ovf), 0);
    adds(1);
    idle(3);
    chk("ovf_res_held", int'(res_level), 99);
    chk("ovf_sticky", int'(res_ovf), 1);
    do_reset();
    chk("ovf_cleared", int'(res_ovf), 0);

    // Dozens: 120 accepted consumes
    adds(99);
    idle(3);
    op_refill(); op_refill(); op_refill(); op_refill();
    adds(99);
    idle(2);
    chk("dz_pre_main", int'(main_level), 99);
    chk("dz_pre_res", int'(res_level), 99);
    dp_cnt = 0; dzw_cnt = 0;
    set_in(1, 1, 0, 0, 1);
    for (int i = 1; i <= 120; i++) begin
      step();
      if (i == 12) chk("dz_first", int'(dozens), 1);
      if (i == 119) chk("dz_before_wrap", int'(dozens), 9);
    end
    consume = 0;
    chk("dz_pulses", dp_cnt, 10);
    chk("dz_wraps", dzw_cnt, 1);
    chk("dz_final", int'(dozens), 0);
    chk("dz_ro", int'(ro), 0);

    // enable=0 mid-refill freezes levels
    do_reset();
    adds(5);
    chk("en_pre_main", int'(main_level), 3);
    chk("en_pre_res", int'(res_level), 2);
    done_cnt = 0;
    set_in(1, 0, 1, 1, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("en_frz_main", int'(main_level), 3);
      chk("en_frz_res", int'(res_level), 2);
      chk("en_frz_busy", int'(xfer_busy), 1);
    end
    set_in(1, 1, 0, 0, 0);
    step();
    chk("en_resume_main", int'(main_level), 4);
    step();
    chk("en_end_main", int'(main_level), 5);
    chk("en_end_res", int'(res_level), 0);
    chk("en_end_busy", int'(xfer_busy), 0);
    chk("en_done_cnt", done_cnt, 1);

    // Reset mid-XFER abandons the refill
    do_reset();
    adds(5);
    chk("rx_pre_busy", int'(xfer_busy), 1);
    done_cnt = 0;
    set_in(0, 1, 0, 0, 0);
    step();
    chk("rx_main", int'(main_level), 0);
    chk("rx_res", int'(res_level), 0);
    chk("rx_busy", int'(xfer_busy), 0);
    idle(3);
    chk("rx_no_done", done_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
